// File: rtl/wb_regfile.sv
// MEM/WB pipeline stage register feeding a 2**ADDR_W x DATA_W register file.
// Two combinational read ports with same-cycle writeback bypass; r0 is hardwired to zero.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic              m_reg_write,
  input  logic              m_mem_to_reg,
  input  logic [ADDR_W-1:0] m_rd,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_mem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic              st_valid;
  logic              st_reg_write;
  logic              st_mem_to_reg;
  logic [ADDR_W-1:0] st_rd;
  logic [DATA_W-1:0] st_alu_result;
  logic [DATA_W-1:0] st_mem_data;

  logic [DATA_W-1:0] regs [NREGS];

  // Flush only kills the instruction; the remaining fields are left as they were.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid      <= 1'b0;
      st_reg_write  <= 1'b0;
      st_mem_to_reg <= 1'b0;
      st_rd         <= '0;
      st_alu_result <= '0;
      st_mem_data   <= '0;
    end else if (flush) begin
      st_valid      <= 1'b0;
    end else if (!stall) begin
      st_valid      <= m_valid;
      st_reg_write  <= m_reg_write;
      st_mem_to_reg <= m_mem_to_reg;
      st_rd         <= m_rd;
      st_alu_result <= m_alu_result;
      st_mem_data   <= m_mem_data;
    end
  end

  assign wb_rd   = st_rd;
  assign wb_data = st_mem_to_reg ? st_mem_data : st_alu_result;
  assign wb_we   = st_valid && st_reg_write && (st_rd != '0);

  // wb_we already excludes r0, so entry 0 is never written after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (wb_we && (ra1 == wb_rd)) begin
      rd1 = wb_data;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (wb_we && (ra2 == wb_rd)) begin
      rd2 = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written reset
// sequences, then randomized traffic compared against an architectural model.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic        m_reg_write;
  logic        m_mem_to_reg;
  logic [4:0]  m_rd;
  logic [31:0] m_alu_result;
  logic [31:0] m_mem_data;
  logic        stall;
  logic        flush;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total_checks = 0;
  int pass_checks  = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_valid      (m_valid),
    .m_reg_write  (m_reg_write),
    .m_mem_to_reg (m_mem_to_reg),
    .m_rd         (m_rd),
    .m_alu_result (m_alu_result),
    .m_mem_data   (m_mem_data),
    .stall        (stall),
    .flush        (flush),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        stall;
    logic        flush;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        exp_we;
    logic        chk_wb;
    logic [4:0]  exp_wb_rd;
    logic [31:0] exp_wb_data;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
  } vec_t;

  // Architectural model: committed register values plus the one instruction in writeback.
  logic [31:0] arch [32];
  typedef struct {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        known;
  } instr_t;
  instr_t wb_slot;

  function automatic logic model_commits();
    return wb_slot.valid && wb_slot.rw && (wb_slot.rd != 5'd0);
  endfunction

  function automatic logic [31:0] model_result();
    return wb_slot.m2r ? wb_slot.mem : wb_slot.alu;
  endfunction

  // A read sees the value the register holds once this cycle's writeback commits.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (model_commits() && wb_slot.rd == a) return model_result();
    return arch[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) arch[i] = 32'd0;
      wb_slot = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1};
    end else begin
      if (model_commits()) arch[wb_slot.rd] = model_result();
      if (flush) begin
        wb_slot.valid = 1'b0;
        wb_slot.known = 1'b0;
      end else if (!stall) begin
        wb_slot = '{m_valid, m_reg_write, m_mem_to_reg, m_rd, m_alu_result, m_mem_data, 1'b1};
      end
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic rw, input logic m2r,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] mem, input logic stall_i,
                              input logic flush_i, input logic [4:0] a1,
                              input logic [4:0] a2, input logic we,
                              input logic chk, input logic [4:0] wrd,
                              input logic [31:0] wdata, input logic [31:0] r1,
                              input logic [31:0] r2);
    vec_t v;
    v.rst_n = 1'b1; v.valid = valid; v.rw = rw; v.m2r = m2r; v.rd = rd;
    v.alu = alu; v.mem = mem; v.stall = stall_i; v.flush = flush_i;
    v.ra1 = a1; v.ra2 = a2; v.exp_we = we; v.chk_wb = chk; v.exp_wb_rd = wrd;
    v.exp_wb_data = wdata; v.exp_rd1 = r1; v.exp_rd2 = r2;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n        = v.rst_n;
    m_valid      = v.valid;
    m_reg_write  = v.rw;
    m_mem_to_reg = v.m2r;
    m_rd         = v.rd;
    m_alu_result = v.alu;
    m_mem_data   = v.mem;
    stall        = v.stall;
    flush        = v.flush;
    ra1          = v.ra1;
    ra2          = v.ra2;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else pass_checks++;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
  endtask

  task automatic check_reads_zero(input string tag);
    for (int a = 0; a < 32; a += 3) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      #1;
      checkOutput({tag, " rd1"}, rd1, 32'd0);
      checkOutput({tag, " rd2"}, rd2, 32'd0);
    end
  endtask

  vec_t nop;
  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    wb_slot = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0};
    nop = mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);

    // Reset with garbage on the inputs, then verify the cleared state.
    begin
      vec_t r;
      r = mk(1, 1, 1, 5'd9, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 0, 0, 5'd1, 5'd2,
             0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
      r.rst_n = 1'b0;
      applyStimulus(r);
      clock_edge();
      applyStimulus(r);
      clock_edge();
      applyStimulus(nop);
      checkOutput("reset wb_we", {31'd0, wb_we}, 32'd0);
      checkOutput("reset wb_rd", {27'd0, wb_rd}, 32'd0);
      checkOutput("reset wb_data", wb_data, 32'd0);
      check_reads_zero("reset");
    end

    //            v  rw m2r rd     alu            mem            st fl ra1    ra2    we chk wbrd   wbdata         rd1            rd2
    tbl[0]  = mk(1, 1, 1, 5'd5, 32'h1,         32'hDEADBEEF, 0, 0, 5'd5, 5'd0, 0, 1, 5'd0, 32'd0,         32'd0,         32'd0);
    tbl[1]  = mk(1, 1, 0, 5'd0, 32'h12345678,  32'd0,        0, 0, 5'd5, 5'd5, 1, 1, 5'd5, 32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF);
    tbl[2]  = mk(1, 1, 0, 5'd3, 32'h11,        32'd0,        0, 0, 5'd5, 5'd0, 0, 1, 5'd0, 32'h12345678,  32'hDEADBEEF,  32'd0);
    tbl[3]  = mk(1, 1, 0, 5'd3, 32'h22,        32'd0,        0, 0, 5'd0, 5'd3, 1, 1, 5'd3, 32'h11,        32'd0,         32'h11);
    tbl[4]  = mk(0, 1, 0, 5'd4, 32'h4444,      32'd0,        0, 0, 5'd0, 5'd3, 1, 1, 5'd3, 32'h22,        32'd0,         32'h22);
    tbl[5]  = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        0, 0, 5'd4, 5'd3, 0, 1, 5'd4, 32'h4444,      32'd0,         32'h22);
    tbl[6]  = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        0, 0, 5'd4, 5'd5, 0, 1, 5'd0, 32'd0,         32'd0,         32'hDEADBEEF);
    tbl[7]  = mk(1, 1, 0, 5'd7, 32'hA5A5A5A5,  32'd0,        0, 0, 5'd0, 5'd7, 0, 1, 5'd0, 32'd0,         32'd0,         32'd0);
    tbl[8]  = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        1, 1, 5'd7, 5'd7, 1, 1, 5'd7, 32'hA5A5A5A5,  32'hA5A5A5A5,  32'hA5A5A5A5);
    tbl[9]  = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        0, 0, 5'd7, 5'd0, 0, 0, 5'd0, 32'd0,         32'hA5A5A5A5,  32'd0);
    tbl[10] = mk(1, 1, 0, 5'd7, 32'h5A5A5A5A,  32'd0,        0, 0, 5'd7, 5'd7, 0, 1, 5'd0, 32'd0,         32'hA5A5A5A5,  32'hA5A5A5A5);
    tbl[11] = mk(1, 1, 0, 5'd6, 32'hBAD,       32'd0,        1, 0, 5'd7, 5'd6, 1, 1, 5'd7, 32'h5A5A5A5A,  32'h5A5A5A5A,  32'd0);
    tbl[12] = mk(1, 1, 0, 5'd6, 32'hBAD,       32'd0,        1, 0, 5'd7, 5'd6, 1, 1, 5'd7, 32'h5A5A5A5A,  32'h5A5A5A5A,  32'd0);
    tbl[13] = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        0, 0, 5'd6, 5'd7, 1, 1, 5'd7, 32'h5A5A5A5A,  32'd0,         32'h5A5A5A5A);
    tbl[14] = mk(0, 0, 0, 5'd0, 32'd0,         32'd0,        0, 0, 5'd6, 5'd7, 0, 1, 5'd0, 32'd0,         32'd0,         32'h5A5A5A5A);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d wb_we", i), {31'd0, wb_we}, {31'd0, tbl[i].exp_we});
      if (tbl[i].chk_wb) begin
        checkOutput($sformatf("vec%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, tbl[i].exp_wb_rd});
        checkOutput($sformatf("vec%0d wb_data", i), wb_data, tbl[i].exp_wb_data);
      end
      checkOutput($sformatf("vec%0d rd1", i), rd1, tbl[i].exp_rd1);
      checkOutput($sformatf("vec%0d rd2", i), rd2, tbl[i].exp_rd2);
      clock_edge();
    end

    // Reset while a write to r9 is held under stall: the held write must be dropped.
    begin
      vec_t v;
      applyStimulus(mk(1, 1, 0, 5'd9, 32'hFFFF0000, 32'd0, 0, 0, 5'd9, 5'd0,
                       0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
      clock_edge();
      applyStimulus(nop);
      clock_edge();
      applyStimulus(mk(1, 1, 0, 5'd9, 32'h1, 32'd0, 0, 0, 5'd9, 5'd9,
                       0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
      checkOutput("midrst old r9", rd1, 32'hFFFF0000);
      clock_edge();
      v = mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 1, 0, 5'd9, 5'd9, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
      v.rst_n = 1'b0;
      applyStimulus(v);
      checkOutput("midrst staged we", {31'd0, wb_we}, 32'd1);
      checkOutput("midrst staged data", wb_data, 32'h1);
      clock_edge();
      applyStimulus(mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 1, 0, 5'd9, 5'd7,
                       0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
      checkOutput("midrst wb_we", {31'd0, wb_we}, 32'd0);
      checkOutput("midrst r9", rd1, 32'd0);
      checkOutput("midrst r7", rd2, 32'd0);
      clock_edge();
      applyStimulus(nop);
      check_reads_zero("postrst");
      clock_edge();
    end

    // Randomized traffic against the architectural model.
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      v = nop;
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.rw    = ($urandom_range(0, 3) != 0);
      v.m2r   = 1'($urandom);
      v.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      v.alu   = $urandom;
      v.mem   = $urandom;
      v.stall = ($urandom_range(0, 3) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.ra1   = ($urandom_range(0, 2) == 0) ? wb_slot.rd : 5'($urandom_range(0, 8));
      v.ra2   = ($urandom_range(0, 2) == 0) ? v.ra1 : 5'($urandom_range(0, 8));
      applyStimulus(v);
      checkOutput("rand wb_we", {31'd0, wb_we}, {31'd0, model_commits()});
      if (wb_slot.known) begin
        checkOutput("rand wb_rd", {27'd0, wb_rd}, {27'd0, wb_slot.rd});
        checkOutput("rand wb_data", wb_data, model_result());
      end
      checkOutput("rand rd1", rd1, model_read(v.ra1));
      checkOutput("rand rd2", rd2, model_read(v.ra2));
      clock_edge();
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
